// File: rtl/mid1_if.sv
// mid1_if: bundle between the memory stage and the write-back stage.
//   master : drives en, flush, rtype, lw, ins, ALURes, MemRes;
//            receives Dest, WBData, RW
//   slave  : the write-back stage (mid1)
interface mid1_if #(
    parameter int DW      = 20,
    parameter int RW_ADDR = 4
);
    logic               en;
    logic               flush;
    logic               rtype;
    logic               lw;
    logic [DW-1:0]      ins;
    logic [DW-1:0]      ALURes;
    logic [DW-1:0]      MemRes;
    logic [RW_ADDR-1:0] Dest;
    logic [DW-1:0]      WBData;
    logic               RW;

    modport master (
        output en, flush, rtype, lw, ins, ALURes, MemRes,
        input  Dest, WBData, RW
    );

    modport slave (
        input  en, flush, rtype, lw, ins, ALURes, MemRes,
        output Dest, WBData, RW
    );
endinterface

// File: rtl/mid1.sv
// mid1: write-back stage of the 20-bit pipeline.
// Captures instruction, ALU result and memory data and presents the
// register-file write port one clock later.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (clears Dest/WBData/RW)
//   wb     : mid1_if.slave
//            in : en (advance), flush (bubble, beats en), rtype, lw,
//                 ins, ALURes, MemRes
//            out: Dest (write index), WBData (write data), RW (write enable)
module mid1 #(
    parameter int DW      = 20,
    parameter int RW_ADDR = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    mid1_if.slave  wb
);
    typedef struct packed {
        logic [RW_ADDR-1:0] dest;
        logic [DW-1:0]      data;
        logic               rw;
    } wb_port_t;

    wb_port_t wb_d;
    wb_port_t wb_q;

    logic [RW_ADDR-1:0] rt;
    logic [RW_ADDR-1:0] rd;

    assign rt = wb.ins[8 +: RW_ADDR];
    assign rd = wb.ins[4 +: RW_ADDR];

    // Opcode, rs and funct are decoded upstream; they are not needed here.
    logic unused_ins_bits;
    assign unused_ins_bits = ^{wb.ins[DW-1:8+RW_ADDR], wb.ins[3:0]};

    // Load wins over R-type, so the illegal rtype&lw encoding behaves as a load.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves it unassigned (no latch).
        wb_d.dest = rd;
        wb_d.data = wb.ALURes;
        wb_d.rw   = wb.rtype;
        if (wb.lw) begin
            wb_d.dest = rt;
            wb_d.data = wb.MemRes;
            wb_d.rw   = 1'b1;
        end
    end

    // Flush inserts a bubble even while stalled; otherwise en gates capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            wb_q <= '0;
        end else if (wb.flush) begin
            wb_q <= '0;
        end else if (wb.en) begin
            wb_q <= wb_d;
        end
    end

    assign wb.Dest   = wb_q.dest;
    assign wb.WBData = wb_q.data;
    assign wb.RW     = wb_q.rw;
endmodule

// File: tb/tb_mid1.sv
// tb_mid1: self-checking bench for mid1 (directed scenarios plus random run
// against a behavioural model of the write-back port).
module tb_mid1;
    localparam int DW      = 20;
    localparam int RW_ADDR = 4;

    logic clk;
    logic rst_n;

    mid1_if #(.DW(DW), .RW_ADDR(RW_ADDR)) bus ();

    mid1 #(.DW(DW), .RW_ADDR(RW_ADDR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model of what the register-file port should show right now.
    logic [RW_ADDR-1:0] m_dest;
    logic [DW-1:0]      m_data;
    logic               m_rw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_dest = '0;
        m_data = '0;
        m_rw   = 1'b0;
    endtask

    // Write-back rule: a load writes memory data to rt; otherwise the ALU
    // result heads for rd and is written only for R-type instructions.
    task automatic model_edge();
        if (!rst_n || bus.flush) begin
            model_clear();
        end else if (bus.en) begin
            if (bus.lw) begin
                m_dest = bus.ins[11:8];
                m_data = bus.MemRes;
                m_rw   = 1'b1;
            end else begin
                m_dest = bus.ins[7:4];
                m_data = bus.ALURes;
                m_rw   = bus.rtype;
            end
        end
    endtask

    // Advance one edge, update the model, sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic check_model(input string tag);
        check({tag, ".Dest"},   32'(bus.Dest),   32'(m_dest));
        check({tag, ".WBData"}, 32'(bus.WBData), 32'(m_data));
        check({tag, ".RW"},     32'(bus.RW),     32'(m_rw));
    endtask

    task automatic check_const(input string tag, input int d, input int w, input int r);
        check({tag, ".Dest"},   32'(bus.Dest),   32'(d));
        check({tag, ".WBData"}, 32'(bus.WBData), 32'(w));
        check({tag, ".RW"},     32'(bus.RW),     32'(r));
    endtask

    task automatic drive(input bit f, input bit e, input bit rt, input bit l,
                         input logic [DW-1:0] i, input logic [DW-1:0] a,
                         input logic [DW-1:0] m);
        bus.flush  = f;
        bus.en     = e;
        bus.rtype  = rt;
        bus.lw     = l;
        bus.ins    = i;
        bus.ALURes = a;
        bus.MemRes = m;
    endtask

    initial begin
        rst_n = 1'b1;
        model_clear();
        drive(0, 1, 1, 0, 20'hABCDE, 20'h12345, 20'h6789A);

        // 1. Load nonzero values, then assert reset between edges.
        tick();
        check_const("pre_reset", 4'hD, 20'h12345, 1);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_const("async_reset", 0, 0, 0);
        tick();
        check_const("reset_held", 0, 0, 0);
        rst_n = 1'b1;

        // 2. R-type
        drive(0, 1, 1, 0, 20'h00C56, 20'd3, 20'd1);
        tick();
        check_const("rtype", 5, 3, 1);
        // 3. Load
        drive(0, 1, 0, 1, 20'h00C56, 20'd3, 20'd1);
        tick();
        check_const("load", 12, 1, 1);
        // 4. Non-writing, then illegal both-set
        drive(0, 1, 0, 0, 20'h00C56, 20'd3, 20'd1);
        tick();
        check_const("nowrite", 5, 3, 0);
        drive(0, 1, 1, 1, 20'h00C56, 20'd3, 20'd1);
        tick();
        check_const("both_set", 12, 1, 1);

        // 5. Stall holds, flush clears even with en=1
        drive(0, 1, 0, 1, 20'h00C56, 20'd3, 20'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 0, 20'(32'h5A5A5 + k), 20'(32'h77 + k), 20'(32'h99 + k));
            tick();
            check_const($sformatf("stall%0d", k), 12, 1, 1);
        end
        drive(1, 1, 1, 0, 20'h00C56, 20'd3, 20'd1);
        tick();
        check_const("flush", 0, 0, 0);
        drive(1, 0, 0, 1, 20'h00C56, 20'd3, 20'd1);
        tick();
        check_const("flush_stalled", 0, 0, 0);

        // 6. Back-to-back R-type writes with an async reset pulse mid-stream
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 1, 0, 20'($urandom), 20'($urandom), 20'($urandom));
            tick();
            check_model($sformatf("b2b%0d", k));
            if (k == 3) begin
                rst_n = 1'b0;
                #1;
                model_clear();
                check_const("midstream_reset", 0, 0, 0);
                rst_n = 1'b1;
            end
        end

        // Random run: inputs change mid-cycle must not reach the outputs
        // before the next edge; occasional async reset pulses.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom),
                  20'($urandom), 20'($urandom), 20'($urandom));
            #1;
            check_model("no_comb_path");
            tick();
            check_model($sformatf("rand%0d", k));
            if ($urandom_range(0, 19) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                model_clear();
                check_model("rand_reset");
                rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule

// File: doc/mid1.md
Name: mid1

Overview:
Write-back stage of the 20-bit processor pipeline. Captures the instruction word, ALU result and memory read data at the end of the memory stage. Produces the register-file write port signals: destination register index, write-back data and write enable. All outputs are registered, one clock after the inputs are presented.

Parameters:
DW, 20, data/instruction width in bits
RW_ADDR, 4, register index width (register file of 2**RW_ADDR entries)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  pipeline advance; outputs update only when 1
flush  input  1  synchronous bubble insert; takes priority over en
rtype  input  1  instruction is R-type (ALU result written to rd)
lw  input  1  instruction is load word (memory data written to rt)
ins  input  DW  instruction word
ALURes  input  DW  ALU result from execute stage
MemRes  input  DW  data read from data memory
Dest  output  RW_ADDR  register-file write address
WBData  output  DW  register-file write data
RW  output  1  register-file write enable

Behaviour:
- One clock, clk. Reset is asynchronous and active-low: rst_n=0 immediately forces Dest=0, WBData=0, RW=0, independent of clk. Release is sampled on the next rising edge.
- Instruction fields (20-bit word):
  - opcode=ins[19:16]
  - rs=ins[15:12]
  - rt=ins[11:8]
  - rd=ins[7:4]
  - funct=ins[3:0]
- Combinational next-state:
  - lw=1: Dest_n=rt, WBData_n=MemRes, RW_n=1.
  - lw=0, rtype=1: Dest_n=rd, WBData_n=ALURes, RW_n=1.
  - Both 0 (store, branch, nop): Dest_n=rd, WBData_n=ALURes, RW_n=0.
  - Both 1 (illegal encoding): lw wins. Dest_n=rt, WBData_n=MemRes, RW_n=1.
- Register update on rising clk with rst_n=1:
  - flush=1: RW<=0, Dest<=0, WBData<=0. Overrides en.
  - flush=0, en=1: outputs <= next-state values.
  - flush=0, en=0: all outputs hold.
- Latency: exactly 1 cycle from input sampling to output. No combinational input-to-output path.
- Data is passed unmodified. No sign extension, no arithmetic.
- Write to register 0 is not suppressed here; the register file handles it.
- Reset asserted mid-operation clears the outputs at once. The in-flight write is lost (RW=0).

Test Plan:
1. Reset: rst_n=0 with nonzero inputs -> Dest=0, WBData=0, RW=0 immediately, with no clock edge needed.
2. R-type: rtype=1, lw=0, ins=20'h00C56, ALURes=3, MemRes=1, en=1, one edge -> Dest=5, WBData=3, RW=1.
3. Load: rtype=0, lw=1, same ins/ALURes/MemRes -> after one edge Dest=12 (4'hC), WBData=1, RW=1.
4. Non-writing instruction: rtype=0, lw=0, ins=20'h00C56 -> RW=0, Dest=5, WBData=ALURes. Then both rtype=1 and lw=1 -> Dest=12, WBData=MemRes, RW=1.
5. Stall/flush: load scenario captured, then en=0 with changed inputs for 3 cycles -> outputs hold at 12/1/1. Then flush=1 with en=1 -> RW=0, Dest=0, WBData=0.
6. Async reset mid-stream: during a run of back-to-back R-type writes, pulse rst_n low between clock edges -> outputs go to 0 at once. After release, the first edge captures the current inputs.
